// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Latency: accept to response pulse is 2 cycles (1 + MULT_LAT cycles for MUL/MULH).
// Backpressure: one op in flight; both readies drop outside IDLE. Responses cannot be stalled.
module alu_share_arbiter #(
    parameter int unsigned MULT_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_result,
    output logic        rsp_branch,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_branch
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] MUL_CNT = 4'(MULT_LAT - 1);

    state_t     state, state_nxt;
    logic       last_grant;
    logic       grant_id;
    logic       grant;
    logic       accept;
    logic [3:0] cnt;
    logic [3:0] sel_op;
    logic       sel_mul;

    // With both ports valid the port that did not win last time is chosen.
    always_comb begin
        grant   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_op  = grant ? req1_op : req0_op;
        sel_mul = (sel_op == 4'b1001) || (sel_op == 4'b1011);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                accept     = req0_valid || req1_valid;
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The op registers feed the ALU directly so its inputs stay still while it settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            cnt        <= 4'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_op     <= 4'd0;
            rsp_result <= 32'd0;
            rsp_branch <= 1'b0;
        end else begin
            if (accept) begin
                grant_id   <= grant;
                last_grant <= grant;
                alu_a      <= grant ? req1_a : req0_a;
                alu_b      <= grant ? req1_b : req0_b;
                alu_op     <= sel_op;
                cnt        <= sel_mul ? MUL_CNT : 4'd0;
            end
            if (state == EXEC) begin
                if (cnt == 4'd0) begin
                    rsp_result <= alu_result;
                    rsp_branch <= alu_branch && (alu_op[3:2] == 2'b11);
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for alu_share_arbiter with a scoreboard and a behavioural ALU.
module tb_alu_share_arbiter;

    localparam int MULT_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp_branch;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_branch;

    alu_share_arbiter #(.MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result), .rsp_branch(rsp_branch),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_branch(alu_branch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    // Reference ALU: {branch, result}. Non-branch ops report a junk branch bit.
    function automatic logic [32:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint     sx, sy, p;
        logic [31:0] r;
        logic        br;
        sx = $signed(a);
        sy = $signed(b);
        p  = sx * sy;
        br = ^(a ^ b);
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b1001: r = p[31:0];
            4'b1011: r = p[63:32];
            4'b1010: r = {b[19:0], 12'h000};
            default: r = a ^ ~b;
        endcase
        if (op[3:2] == 2'b11) begin
            r = 32'hFFFF_FFFF;
            case (op[1:0])
                2'b00: br = (a == b);
                2'b01: br = (a != b);
                2'b10: br = ($signed(a) < $signed(b));
                default: br = (a >= b);
            endcase
        end
        return {br, r};
    endfunction

    // ALU stand-in: multiply outputs are garbage until the inputs have been still long enough.
    logic [67:0] last_in = '0;
    int          age = 0;
    always begin
        @(posedge clk);
        #1;
        if ({alu_op, alu_a, alu_b} != last_in) begin
            last_in = {alu_op, alu_a, alu_b};
            age = 0;
        end else if (age < 100) begin
            age = age + 1;
        end
    end

    always_comb begin
        {alu_branch, alu_result} = alu_fn(alu_op, alu_a, alu_b);
        if ((alu_op == 4'b1001 || alu_op == 4'b1011) && age < MULT_LAT - 1)
            alu_result = 32'hDEAD_BEEF ^ alu_a;
    end

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic        br;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Response monitor: every rsp pulse must match the oldest expectation, on its cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (rsp0_valid || rsp1_valid) begin
            check("rsp_onehot", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp0=%0b rsp1=%0b expected none at cycle %0d", rsp0_valid, rsp1_valid, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_port", {31'b0, rsp1_valid}, {31'b0, mon_e.port});
                check("rsp_result", rsp_result, mon_e.res);
                check("rsp_branch", {31'b0, rsp_branch}, {31'b0, mon_e.br});
                check("rsp_cycle", cyc, mon_e.cyc);
            end
        end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: got no pulse expected port %0d at cycle %0d", sb[0].port, sb[0].cyc);
            mon_e = sb.pop_front();
        end
    end

    // Arbitration model, evaluated mid-cycle on the inputs the bench is driving.
    logic m_last = 1'b1;
    int   free_at = 0;
    logic acc0, acc1;

    task automatic model_step();
        logic        e0, e1, g, br;
        logic [3:0]  op;
        logic [31:0] a, b, r;
        int          l;
        exp_t        e;
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst_n && cyc >= free_at && (req0_valid || req1_valid)) begin
            g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0 = !g;
            e1 = g;
            op = g ? req1_op : req0_op;
            a  = g ? req1_a : req0_a;
            b  = g ? req1_b : req0_b;
            l  = (op == 4'b1001 || op == 4'b1011) ? MULT_LAT : 1;
            {br, r} = alu_fn(op, a, b);
            e.port = g;
            e.res  = r;
            e.br   = br && (op[3:2] == 2'b11);
            e.cyc  = cyc + 1 + l;
            sb.push_back(e);
            m_last  = g;
            free_at = cyc + 2 + l;
        end
        if (rst_n) begin
            check("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
            check("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
        end
        acc0 = e0;
        acc1 = e1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic done;
        done = 1'b0;
        if (p) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            done = p ? acc1 : acc0;
        end
        check("issue_accept", {31'b0, done}, 32'd1);
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic check_all_zero();
        check("z_req0_ready", {31'b0, req0_ready}, 32'd0);
        check("z_req1_ready", {31'b0, req1_ready}, 32'd0);
        check("z_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        check("z_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        check("z_rsp_result", rsp_result, 32'd0);
        check("z_rsp_branch", {31'b0, rsp_branch}, 32'd0);
        check("z_alu_a", alu_a, 32'd0);
        check("z_alu_b", alu_b, 32'd0);
        check("z_alu_op", {28'b0, alu_op}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single add, then multiplies on port 1.
        issue(1'b0, 32'd5, 32'd7, 4'b0000);
        idle(4);
        issue(1'b1, -32'sd3, 32'd4, 4'b1001);
        idle(6);
        issue(1'b1, -32'sd3, 32'd4, 4'b1011);
        idle(6);

        // Both ports valid continuously.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 4'b0000;
        idle(12);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        idle(4);

        // Branches.
        issue(1'b0, 32'h1234, 32'h1234, 4'b1100);
        issue(1'b0, 32'd1, 32'd2, 4'b1100);
        issue(1'b1, 32'hFFFF_FFFF, 32'd0, 4'b1111);
        idle(4);

        // Reset in the second EXEC cycle of a multiply.
        issue(1'b0, 32'd9, 32'd9, 4'b1001);
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero();
        free_at = 0;
        m_last  = 1'b1;
        tick();
        rst_n = 1'b1;
        idle(6);
        issue(1'b0, 32'd3, 32'd4, 4'b0000);
        idle(4);
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'b0001;
        req1_valid = 1'b1; req1_a = 32'd30; req1_b = 32'd40; req1_op = 4'b0100;
        idle(6);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        idle(4);

        // Port 1 withdraws while port 0's multiply is executing.
        issue(1'b0, 32'd5, 32'd6, 4'b1001);
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 4'b0000;
        tick();
        check("withdraw_alu_op", {28'b0, alu_op}, 32'h9);
        req1_valid = 1'b0;
        idle(6);

        // Random traffic with holds, withdrawals and fresh ops.
        for (int i = 0; i < 1500; i++) begin
            if (acc0 || (req0_valid && $urandom_range(0, 7) == 0) || (!req0_valid && $urandom_range(0, 1) == 0)) begin
                req0_valid = (!acc0 && req0_valid) ? 1'b0 : 1'($urandom_range(0, 1));
                req0_a  = $urandom;
                req0_b  = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
                req0_op = 4'($urandom_range(0, 15));
            end
            if (acc1 || (req1_valid && $urandom_range(0, 7) == 0) || (!req1_valid && $urandom_range(0, 1) == 0)) begin
                req1_valid = (!acc1 && req1_valid) ? 1'b0 : 1'($urandom_range(0, 1));
                req1_a  = $urandom;
                req1_b  = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
                req1_op = 4'($urandom_range(0, 15));
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        idle(25);
        check("drain_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
